ysyx_24100029_axi_sram: RTL and testbench
=========================================

YSYX_24100029_AXI_SRAM -- requirements
Module: ysyx_24100029_axi_sram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h30000000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words; power of two.
REQ-003 SHALL have parameter RD_LATENCY, default 2, cycles from AR handshake to first rvalid; legal range 1..15.
REQ-004 SHALL have ports: clock in 1 sole clock; reset in 1 synchronous active-low reset.
REQ-005 SHALL have AW ports: awvalid in 1; awready out 1; awaddr in 32; awid in 4; awlen in 8; awsize in 3; awburst in 2.
REQ-006 SHALL have W ports: wvalid in 1; wready out 1; wdata in 32; wstrb in 4; wlast in 1.
REQ-007 SHALL have B ports: bvalid out 1; bready in 1; bresp out 2; bid out 4.
REQ-008 SHALL have AR ports: arvalid in 1; arready out 1; araddr in 32; arid in 4; arlen in 8; arsize in 3; arburst in 2.
REQ-009 SHALL have R ports: rvalid out 1; rready in 1; rresp out 2; rdata out 32; rlast out 1; rid out 4.

Function
REQ-010 SHALL implement an AXI4 slave: read and write channels run as independent FSMs sharing one DEPTH_WORDS x 32 storage array.
REQ-011 SHALL decode a beat as in-range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS; word index = (addr-BASE_ADDR)>>2; addr[1:0] ignored; awsize/arsize ignored, always 4-byte beats.
REQ-012 SHALL support bursts FIXED (00), where every beat uses the start address, and INCR (01), where the address advances by 4 per beat with no wrap at 4 KB; WRAP (10) and 11 SHALL answer every beat with SLVERR without touching storage.
REQ-013 Read FSM SHALL have states R_IDLE, R_WAIT, R_DATA; arready=1 only in R_IDLE.
REQ-014 On arvalid&arready the block SHALL latch araddr, arid, arlen, arburst, load latency counter RD_LATENCY-1, and enter R_WAIT.
REQ-015 R_WAIT SHALL decrement the counter each cycle and enter R_DATA on the cycle the counter is 0; first rvalid rises exactly RD_LATENCY cycles after the AR handshake edge.
REQ-016 In R_DATA, rvalid=1, rid=latched arid, rdata=current word (0 if out of range or error), rresp=00 OKAY or 10 SLVERR, rlast=1 iff beat count == arlen.
REQ-017 R outputs SHALL stay stable while rvalid&~rready; on rvalid&rready the beat counter and address SHALL advance; after the rlast beat the FSM SHALL return to R_IDLE, so back-to-back reads have one idle cycle.
REQ-018 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-019 On the AW handshake the block SHALL latch awaddr, awid, awlen, awburst, clear an error flag, and enter W_DATA.
REQ-020 Each W handshake SHALL write bytes whose wstrb bit is 1 when in range and burst is legal, and SHALL otherwise set the error flag without writing.
REQ-021 wlast SHALL be ignored; the block SHALL enter W_RESP after beat awlen+1. A wlast mismatch SHALL set the error flag.
REQ-022 W_RESP SHALL drive bid=latched awid and bresp=10 if the error flag is set, else 00, and hold until bready, then return to W_IDLE.
REQ-023 A same-cycle write beat and read data fetch to the same word SHALL return the pre-write data; the write SHALL be visible from the next cycle.
REQ-024 The block SHALL never accept wvalid beats before their AW handshake; early wvalid SHALL wait.

Reset
REQ-025 While reset==0 at a clock edge, both FSMs SHALL go idle and all counters SHALL clear; after that edge awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, rresp=0, bresp=0, rdata=0, rid=0, bid=0.
REQ-026 The cycle after reset deasserts, awready=1 and arready=1.
REQ-027 Reset asserted mid-burst SHALL abandon the transaction with no response; storage contents SHALL be kept.
REQ-028 Storage SHALL not be initialised by reset; the bench SHALL preload it via hierarchical access or writes.

Verification
REQ-029 Single write then read: AW 0x30000010 len0, W 0xDEADBEEF strb 1111 -> bresp 00; AR 0x30000010 len0 -> rvalid exactly 2 cycles after handshake, rdata DEADBEEF, rlast 1, rresp 00.
REQ-030 INCR read burst len3 at 0x30000000 with rready toggling 1,0,1,0 -> 4 beats of words 0..3, data held during stalls, rlast only on 4th beat, rid equals arid 0x5.
REQ-031 Byte strobe: preload 0x11223344, write 0xAABBCCDD strb 0101 -> readback 0x11BB33DD.
REQ-032 Out-of-range: AR 0x2FFFFFFC -> rresp 10, rdata 0; AW 0x30001000 (DEPTH 1024) -> bresp 10 and storage unchanged.
REQ-033 WRAP burst len1 -> both R beats SLVERR; FIXED write burst len2 to 0x30000008 with data 1,2,3 -> word 2 holds 3.
REQ-034 Reset pulled low during a R_DATA stall -> rvalid 0 the next cycle and arready 1 after release; previously written data still reads back correctly.

Source files
------------

// File: rtl/ysyx_24100029_axi_sram.sv
// AXI4 slave SRAM: independent read/write FSMs over one word array.
// Registered read data, byte-strobed writes, SLVERR on range/burst errors.
module ysyx_24100029_axi_sram #(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          RD_LATENCY  = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awid,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   output logic [3:0]  bid,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic [3:0]  arid,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   output logic        rvalid,
   input  logic        rready,
   output logic [1:0]  rresp,
   output logic [31:0] rdata,
   output logic        rlast,
   output logic [3:0]  rid
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   function automatic logic in_range(input logic [31:0] a);
      return ({1'b0, a} - {1'b0, BASE_ADDR}) < SPAN;
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
      return AW'((a - BASE_ADDR) >> 2);
   endfunction

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [31:0] mem [DEPTH_WORDS];

   r_state_t    r_state, r_nxt;
   w_state_t    w_state, w_nxt;
   logic        up;
   logic [3:0]  r_lat;
   logic [7:0]  r_len, r_cnt, w_len, w_cnt;
   logic [31:0] r_addr, r_addr_nx, f_addr, w_addr;
   logic [1:0]  r_burst, w_burst;
   logic        w_err;
   logic        ar_hs, aw_hs, w_hs, w_end;
   logic        f_en, f_ok, w_ok;
   logic        unused_size;

   assign unused_size = ^{awsize, arsize};

   assign arready = up && (r_state == R_IDLE);
   assign rvalid  = (r_state == R_DATA);
   assign rlast   = rvalid && (r_cnt == r_len);
   assign ar_hs   = arvalid && arready;

   assign awready = up && (w_state == W_IDLE);
   assign wready  = (w_state == W_DATA);
   assign bvalid  = (w_state == W_RESP);
   assign bresp   = (bvalid && w_err) ? 2'b10 : 2'b00;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign w_end   = (w_cnt == w_len);
   assign w_ok    = in_range(w_addr) && !w_burst[1];

   // Fetch the first beat as the wait ends, later beats on acceptance.
   assign r_addr_nx = (r_burst == 2'b01) ? r_addr + 32'd4 : r_addr;
   assign f_addr    = (r_state == R_WAIT) ? r_addr : r_addr_nx;
   assign f_ok      = in_range(f_addr) && !r_burst[1];
   assign f_en      = ((r_state == R_WAIT) && (r_lat == 4'd0)) ||
                      (rvalid && rready && !rlast);

   always_comb begin
      r_nxt = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_hs) r_nxt = R_WAIT;
         R_WAIT:  if (r_lat == 4'd0) r_nxt = R_DATA;
         R_DATA:  if (rready && rlast) r_nxt = R_IDLE;
         default: r_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      w_nxt = w_state;
      unique case (w_state)
         W_IDLE:  if (aw_hs) w_nxt = W_DATA;
         W_DATA:  if (w_hs && w_end) w_nxt = W_RESP;
         W_RESP:  if (bready) w_nxt = W_IDLE;
         default: w_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
         up      <= 1'b0;
      end else begin
         r_state <= r_nxt;
         w_state <= w_nxt;
         up      <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_lat   <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_burst <= '0;
         rid     <= '0;
         rdata   <= '0;
         rresp   <= '0;
      end else begin
         if (ar_hs) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_burst <= arburst;
            rid     <= arid;
            r_cnt   <= '0;
            r_lat   <= 4'(RD_LATENCY - 1);
         end
         if ((r_state == R_WAIT) && (r_lat != 4'd0))
            r_lat <= r_lat - 4'd1;
         if (rvalid && rready) begin
            r_addr <= r_addr_nx;
            r_cnt  <= r_cnt + 8'd1;
         end
         if (f_en) begin
            rdata <= f_ok ? mem[word_idx(f_addr)] : 32'h0;
            rresp <= f_ok ? 2'b00 : 2'b10;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         w_addr  <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_burst <= '0;
         w_err   <= 1'b0;
         bid     <= '0;
      end else begin
         if (aw_hs) begin
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_burst <= awburst;
            bid     <= awid;
            w_cnt   <= '0;
            w_err   <= 1'b0;
         end
         if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (w_burst == 2'b01)
               w_addr <= w_addr + 32'd4;
            if (!w_ok || (wlast != w_end))
               w_err <= 1'b1;
         end
      end
   end

   // Storage has no reset; writes are blocked while reset is held.
   always_ff @(posedge clock) begin
      if (reset && w_hs && w_ok) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b])
               mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_ysyx_24100029_axi_sram.sv
// Directed bench for the AXI SRAM: vector table of single-beat
// transactions plus hand sequences for bursts, stalls and reset.
module tb_ysyx_24100029_axi_sram;

   logic        clock = 1'b0;
   logic        reset;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid, rready;
   logic [1:0]  rresp;
   logic [31:0] rdata;
   logic        rlast;
   logic [3:0]  rid;

   always #5 clock = ~clock;

   ysyx_24100029_axi_sram dut (
      .clock(clock), .reset(reset),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rresp(rresp),
      .rdata(rdata), .rlast(rlast), .rid(rid)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [1:0]  burst;
      logic [3:0]  id;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdat;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] gd [16];
   logic [1:0]  gr [16];
   logic        gl [16];
   logic [3:0]  gi [16];
   int          lat;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] len,
                     input logic [1:0] bu, input logic [3:0] id,
                     input logic [31:0] d [4], input logic [3:0] st,
                     input bit bad_last, output logic [1:0] resp,
                     output logic [3:0] bidv);
      int n;
      awaddr = a; awlen = len; awburst = bu; awid = id; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 20) begin step(); n++; end
      chk("awready", awready, 1);
      step();
      awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wvalid = 1'b1;
         wdata  = d[i];
         wstrb  = st;
         wlast  = (i == int'(len)) ^ bad_last;
         n = 0;
         while (!wready && n < 20) begin step(); n++; end
         chk("wready", wready, 1);
         step();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin step(); n++; end
      chk("bvalid", bvalid, 1);
      resp   = bresp;
      bidv   = bid;
      bready = 1'b1;
      step();
      bready = 1'b0;
      chk("bvalid_drop", bvalid, 0);
   endtask

   task automatic ar_send(input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] bu, input logic [3:0] id);
      int n;
      araddr = a; arlen = len; arburst = bu; arid = id; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin step(); n++; end
      chk("arready", arready, 1);
      step();
      arvalid = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] len,
                     input logic [1:0] bu, input logic [3:0] id);
      int n;
      ar_send(a, len, bu, id);
      lat = 0;
      while (!rvalid && lat < 20) begin step(); lat++; end
      rready = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         n = 0;
         while (!rvalid && n < 20) begin step(); n++; end
         chk("rvalid", rvalid, 1);
         gd[i] = rdata; gr[i] = rresp; gl[i] = rlast; gi[i] = rid;
         step();
      end
      rready = 1'b0;
   endtask

   vec_t        tbl [17];
   logic [31:0] dd [4];
   logic [31:0] aw [4];
   logic [1:0]  resp;
   logic [3:0]  bidv;
   int          k;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1, 32'h3000_0000, 2'b01, 4'h1, 32'h0101_0101, 4'hF, 2'b00, 32'h0};
      tbl[1]  = '{1'b1, 32'h3000_0010, 2'b01, 4'h2, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
      tbl[2]  = '{1'b0, 32'h3000_0010, 2'b01, 4'h3, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF};
      tbl[3]  = '{1'b1, 32'h3000_0020, 2'b01, 4'h4, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
      tbl[4]  = '{1'b1, 32'h3000_0020, 2'b01, 4'h5, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
      tbl[5]  = '{1'b0, 32'h3000_0020, 2'b01, 4'h6, 32'h0, 4'h0, 2'b00, 32'h11BB_33DD};
      tbl[6]  = '{1'b0, 32'h2FFF_FFFC, 2'b01, 4'h7, 32'h0, 4'h0, 2'b10, 32'h0};
      tbl[7]  = '{1'b1, 32'h3000_1000, 2'b01, 4'h8, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
      tbl[8]  = '{1'b0, 32'h3000_0000, 2'b01, 4'h9, 32'h0, 4'h0, 2'b00, 32'h0101_0101};
      tbl[9]  = '{1'b1, 32'h3000_0FFC, 2'b01, 4'hA, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
      tbl[10] = '{1'b0, 32'h3000_0FFC, 2'b01, 4'hB, 32'h0, 4'h0, 2'b00, 32'hCAFE_F00D};
      tbl[11] = '{1'b0, 32'h3000_1000, 2'b01, 4'hC, 32'h0, 4'h0, 2'b10, 32'h0};
      tbl[12] = '{1'b1, 32'h3000_0013, 2'b01, 4'hD, 32'h5566_7788, 4'hF, 2'b00, 32'h0};
      tbl[13] = '{1'b0, 32'h3000_0010, 2'b01, 4'hE, 32'h0, 4'h0, 2'b00, 32'h5566_7788};
      tbl[14] = '{1'b1, 32'h3000_0010, 2'b10, 4'hF, 32'h9999_9999, 4'hF, 2'b10, 32'h0};
      tbl[15] = '{1'b0, 32'h3000_0010, 2'b11, 4'h0, 32'h0, 4'h0, 2'b10, 32'h0};
      tbl[16] = '{1'b0, 32'h3000_0010, 2'b01, 4'h1, 32'h0, 4'h0, 2'b00, 32'h5566_7788};

      reset   = 1'b0;
      awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 3'd2; awburst = 0;
      wvalid  = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
      arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 3'd2; arburst = 0;
      rready  = 0;
      step(); step(); step();

      chk("rst awready", awready, 0);
      chk("rst arready", arready, 0);
      chk("rst wready", wready, 0);
      chk("rst bvalid", bvalid, 0);
      chk("rst rvalid", rvalid, 0);
      chk("rst rlast", rlast, 0);
      chk("rst rresp", rresp, 0);
      chk("rst bresp", bresp, 0);
      chk("rst rdata", rdata, 0);
      chk("rst rid", rid, 0);
      chk("rst bid", bid, 0);

      reset = 1'b1;
      step();
      chk("post awready", awready, 1);
      chk("post arready", arready, 1);

      wvalid = 1'b1; wdata = 32'hBAD0_BAD0; wstrb = 4'hF; wlast = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("early wready", wready, 0);
         step();
      end
      wvalid = 1'b0; wlast = 1'b0;

      for (int v = 0; v < 17; v++) begin
         if (tbl[v].wr) begin
            dd = '{tbl[v].data, 32'h0, 32'h0, 32'h0};
            wr(tbl[v].addr, 8'd0, tbl[v].burst, tbl[v].id, dd,
               tbl[v].strb, 1'b0, resp, bidv);
            chk($sformatf("v%0d bresp", v), resp, tbl[v].resp);
            chk($sformatf("v%0d bid", v), bidv, tbl[v].id);
         end else begin
            rd(tbl[v].addr, 8'd0, tbl[v].burst, tbl[v].id);
            chk($sformatf("v%0d latency", v), lat, 2);
            chk($sformatf("v%0d rresp", v), gr[0], tbl[v].resp);
            chk($sformatf("v%0d rdata", v), gd[0], tbl[v].rdat);
            chk($sformatf("v%0d rlast", v), gl[0], 1);
            chk($sformatf("v%0d rid", v), gi[0], tbl[v].id);
         end
      end

      aw = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
      wr(32'h3000_0000, 8'd3, 2'b01, 4'h2, aw, 4'hF, 1'b0, resp, bidv);
      chk("incr wr bresp", resp, 2'b00);

      ar_send(32'h3000_0000, 8'd3, 2'b01, 4'h5);
      lat = 0;
      while (!rvalid && lat < 20) begin step(); lat++; end
      chk("burst latency", lat, 2);
      k = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         rready = ~c[0];
         if (!rvalid) begin
            chk("burst rvalid", rvalid, 1);
            break;
         end
         chk($sformatf("burst b%0d rdata", k), rdata, aw[k]);
         chk($sformatf("burst b%0d rlast", k), rlast, (k == 3));
         chk($sformatf("burst b%0d rid", k), rid, 4'h5);
         chk($sformatf("burst b%0d rresp", k), rresp, 2'b00);
         if (rready) k++;
         step();
      end
      rready = 1'b0;
      chk("burst beats", k, 4);
      chk("burst end rvalid", rvalid, 0);

      rd(32'h3000_0000, 8'd1, 2'b10, 4'h6);
      chk("wrap b0 rresp", gr[0], 2'b10);
      chk("wrap b1 rresp", gr[1], 2'b10);
      chk("wrap b0 rdata", gd[0], 0);
      chk("wrap b0 rlast", gl[0], 0);
      chk("wrap b1 rlast", gl[1], 1);

      dd = '{32'h1, 32'h2, 32'h3, 32'h0};
      wr(32'h3000_0008, 8'd2, 2'b00, 4'h7, dd, 4'hF, 1'b0, resp, bidv);
      chk("fixed bresp", resp, 2'b00);
      rd(32'h3000_0008, 8'd0, 2'b01, 4'h7);
      chk("fixed word2", gd[0], 32'h3);
      rd(32'h3000_000C, 8'd0, 2'b01, 4'h7);
      chk("fixed word3", gd[0], 32'hA333_3333);

      dd = '{32'h7777_7777, 32'h0, 32'h0, 32'h0};
      wr(32'h3000_0040, 8'd0, 2'b01, 4'h8, dd, 4'hF, 1'b1, resp, bidv);
      chk("wlast bresp", resp, 2'b10);

      dd = '{32'h1111_1111, 32'h0, 32'h0, 32'h0};
      wr(32'h3000_0050, 8'd0, 2'b01, 4'h1, dd, 4'hF, 1'b0, resp, bidv);
      awaddr = 32'h3000_0050; awlen = 0; awburst = 2'b01; awid = 4'h4;
      awvalid = 1'b1;
      chk("same awready", awready, 1);
      step();
      awvalid = 1'b0;
      araddr = 32'h3000_0050; arlen = 0; arburst = 2'b01; arid = 4'h3;
      arvalid = 1'b1;
      chk("same arready", arready, 1);
      step();
      arvalid = 1'b0;
      step();
      wvalid = 1'b1; wdata = 32'h2222_2222; wstrb = 4'hF; wlast = 1'b1;
      chk("same wready", wready, 1);
      step();
      wvalid = 1'b0; wlast = 1'b0;
      chk("same rvalid", rvalid, 1);
      chk("same rdata old", rdata, 32'h1111_1111);
      rready = 1'b1;
      step();
      rready = 1'b0;
      chk("same bvalid", bvalid, 1);
      chk("same bresp", bresp, 2'b00);
      bready = 1'b1;
      step();
      bready = 1'b0;
      rd(32'h3000_0050, 8'd0, 2'b01, 4'h3);
      chk("same rdata new", gd[0], 32'h2222_2222);

      ar_send(32'h3000_0010, 8'd1, 2'b01, 4'h9);
      k = 0;
      while (!rvalid && k < 20) begin step(); k++; end
      step();
      chk("stall rvalid", rvalid, 1);
      reset = 1'b0;
      step();
      chk("rst mid rvalid", rvalid, 0);
      chk("rst mid arready", arready, 0);
      reset = 1'b1;
      step();
      chk("rel arready", arready, 1);
      chk("rel awready", awready, 1);
      chk("rel rvalid", rvalid, 0);
      rd(32'h3000_0010, 8'd0, 2'b01, 4'hA);
      chk("kept rdata", gd[0], 32'h5566_7788);
      chk("kept rresp", gr[0], 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
